// File: rtl/decrypt.sv
`default_nettype none
// ============================================================================
// Module   : decrypt
// Brief    : LWE decryption, computes b - <a,s> mod q and rounds to mod p.
// Revision : 1.0
// ============================================================================
module decrypt #(
    parameter int PLAINTEXT_MODULUS  = 64,
    parameter int PLAINTEXT_WIDTH    = 6,
    parameter int CIPHERTEXT_MODULUS = 1024,
    parameter int CIPHERTEXT_WIDTH   = 10,
    parameter int DIMENSION          = 10
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [CIPHERTEXT_WIDTH-1:0] ct_data,
    input  logic                        ct_valid,
    input  logic                        ct_last,
    output logic                        ct_ready,
    input  logic [CIPHERTEXT_WIDTH-1:0] secretkey [DIMENSION-1:0],
    output logic [PLAINTEXT_WIDTH-1:0]  pt_data,
    output logic                        pt_valid,
    input  logic                        pt_ready,
    output logic                        frame_err
);

    localparam int CW    = CIPHERTEXT_WIDTH;
    localparam int PW    = PLAINTEXT_WIDTH;
    localparam int SH    = CW - PW;
    localparam int CNT_W = $clog2(DIMENSION + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(DIMENSION);
    localparam logic [CW-1:0]    ROUND_HALF = CW'(CIPHERTEXT_MODULUS / (2 * PLAINTEXT_MODULUS));

    typedef enum logic [0:0] {
        RECV = 1'b0,
        OUT  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] beat_cnt;
    logic [CW-1:0]    acc;
    logic [CW-1:0]    key_sel;
    logic [CW-1:0]    prod;
    logic [CW-1:0]    acc_next;
    logic [CW-1:0]    rounded_sum;
    logic [PW-1:0]    pt_next;
    logic             beat_fire;
    logic             is_final;
    logic             bad_last;

    assign ct_ready  = (state == RECV);
    assign pt_valid  = (state == OUT);
    assign beat_fire = ct_valid && (state == RECV);
    assign is_final  = (beat_cnt == LAST_BEAT);
    // ct_last must appear exactly on the final beat; any other pairing is malformed
    assign bad_last  = (ct_last != is_final);

    always_comb begin
        key_sel = '0;
        for (int i = 0; i < DIMENSION; i++) begin
            if (beat_cnt == CNT_W'(i + 1)) begin
                key_sel = secretkey[i];
            end
        end
    end

    assign prod        = ct_data * key_sel;
    assign acc_next    = (beat_cnt == '0) ? ct_data : (acc - prod);
    assign rounded_sum = acc_next + ROUND_HALF;
    assign pt_next     = PW'(rounded_sum >> SH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RECV;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            RECV: begin
                if (beat_fire && is_final && !bad_last) begin
                    state_next = OUT;
                end
            end
            OUT: begin
                if (pt_ready) begin
                    state_next = RECV;
                end
            end
            default: state_next = RECV;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt  <= '0;
            acc       <= '0;
            pt_data   <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (beat_fire) begin
                if (bad_last) begin
                    beat_cnt  <= '0;
                    frame_err <= 1'b1;
                end else if (is_final) begin
                    acc     <= acc_next;
                    pt_data <= pt_next;
                end else begin
                    acc      <= acc_next;
                    beat_cnt <= beat_cnt + CNT_W'(1);
                end
            end else if ((state == OUT) && pt_ready) begin
                beat_cnt <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decrypt.sv
`default_nettype none
// ============================================================================
// Module   : tb_decrypt
// Brief    : Randomized self-checking bench for decrypt against an integer model.
// Revision : 1.0
// ============================================================================
module tb_decrypt;

    localparam int Q   = 1024;
    localparam int P   = 64;
    localparam int N   = 10;
    localparam int DEL = Q / P;

    logic       clk;
    logic       rst_n;
    logic [9:0] ct_data;
    logic       ct_valid;
    logic       ct_last;
    logic       ct_ready;
    logic [9:0] key [N-1:0];
    logic [5:0] pt_data;
    logic       pt_valid;
    logic       pt_ready;
    logic       frame_err;

    int tests_run;
    int fails;
    int a_vec [N];
    int frame [N+1];

    decrypt #(
        .PLAINTEXT_MODULUS (P),
        .PLAINTEXT_WIDTH   (6),
        .CIPHERTEXT_MODULUS(Q),
        .CIPHERTEXT_WIDTH  (10),
        .DIMENSION         (N)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ct_data  (ct_data),
        .ct_valid (ct_valid),
        .ct_last  (ct_last),
        .ct_ready (ct_ready),
        .secretkey(key),
        .pt_data  (pt_data),
        .pt_valid (pt_valid),
        .pt_ready (pt_ready),
        .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Plain-integer decryption: (b - sum a_i*s_i) mod q, then round to nearest multiple of q/p.
    function automatic int model_pt(input int b);
        int acc;
        acc = b;
        for (int i = 0; i < N; i++) acc = acc - a_vec[i] * int'(key[i]);
        acc = ((acc % Q) + Q) % Q;
        return (((acc + DEL / 2) % Q) / DEL) % P;
    endfunction

    function automatic void build_frame(input int b);
        frame[0] = b;
        for (int k = 1; k <= N; k++) frame[k] = a_vec[k-1];
    endfunction

    task automatic set_key_all(input int v);
        for (int i = 0; i < N; i++) key[i] = 10'(v);
    endtask

    task automatic set_a_all(input int v);
        for (int i = 0; i < N; i++) a_vec[i] = v;
    endtask

    // Drives nbeats words of frame[]; ct_last on beat last_at (-1 = never). Returns #1 after last edge.
    task automatic send_beats(input int nbeats, input int last_at, input bit gaps);
        for (int k = 0; k < nbeats; k++) begin
            if (gaps) begin
                int idle;
                idle = $urandom_range(0, 2);
                for (int g = 0; g < idle; g++) begin
                    ct_valid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            ct_valid = 1'b1;
            ct_data  = 10'(frame[k]);
            ct_last  = (k == last_at);
            @(posedge clk); #1;
        end
        ct_valid = 1'b0;
        ct_last  = 1'b0;
    endtask

    task automatic apply_reset;
        rst_n = 1'b0;
        #7;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Sends a good frame, checks latency/output against expected, then releases the output.
    task automatic decode_and_check(input string name, input int b, input int expected, input bit gaps);
        build_frame(b);
        send_beats(N + 1, N, gaps);
        tests_run++;
        if (pt_valid !== 1'b1 || ct_ready !== 1'b0) begin
            fails++;
            $display("FAIL %s handshake: pt_valid=%0b ct_ready=%0b required 1/0", name, pt_valid, ct_ready);
        end
        tests_run++;
        if (pt_data !== 6'(expected)) begin
            fails++;
            $display("FAIL %s data: got %0d required %0d", name, pt_data, expected);
        end
        pt_ready = 1'b1;
        @(posedge clk); #1;
        pt_ready = 1'b0;
        tests_run++;
        if (ct_ready !== 1'b1 || pt_valid !== 1'b0) begin
            fails++;
            $display("FAIL %s release: ct_ready=%0b pt_valid=%0b required 1/0", name, ct_ready, pt_valid);
        end
    endtask

    task automatic test_reset;
        apply_reset();
        tests_run++;
        if (ct_ready !== 1'b1 || pt_valid !== 1'b0 || pt_data !== 6'd0 || frame_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_values: ct_ready=%0b pt_valid=%0b pt_data=%0d frame_err=%0b required 1/0/0/0",
                     ct_ready, pt_valid, pt_data, frame_err);
        end
    endtask

    task automatic test_basic;
        set_key_all(0);
        set_a_all(0);
        decode_and_check("basic", 80, 5, 1'b0);
    endtask

    task automatic test_rounding;
        set_key_all(1);
        set_a_all(1);
        decode_and_check("round_b97", 97, 5, 1'b0);
        decode_and_check("round_b98", 98, 6, 1'b0);
        decode_and_check("round_wrap", 9, 0, 1'b0);
    endtask

    task automatic test_neg_wrap;
        set_key_all(0);
        key[0] = 10'd16;
        set_a_all(0);
        a_vec[0] = 1;
        decode_and_check("neg_wrap", 0, 63, 1'b0);
    endtask

    task automatic test_random_stalls;
        for (int t = 0; t < 20; t++) begin
            int b;
            for (int i = 0; i < N; i++) begin
                key[i]   = 10'($urandom_range(0, Q - 1));
                a_vec[i] = $urandom_range(0, Q - 1);
            end
            b = $urandom_range(0, Q - 1);
            decode_and_check("random_stall", b, model_pt(b), 1'b1);
        end
    endtask

    task automatic test_backpressure;
        int b;
        logic [5:0] held;
        for (int i = 0; i < N; i++) begin
            key[i]   = 10'($urandom_range(0, Q - 1));
            a_vec[i] = $urandom_range(0, Q - 1);
        end
        b = $urandom_range(0, Q - 1);
        build_frame(b);
        send_beats(N + 1, N, 1'b0);
        held = pt_data;
        tests_run++;
        if (held !== 6'(model_pt(b))) begin
            fails++;
            $display("FAIL bp_data: got %0d required %0d", held, model_pt(b));
        end
        for (int c = 0; c < 5; c++) begin
            ct_valid = 1'b1;
            ct_data  = 10'($urandom_range(0, Q - 1));
            @(posedge clk); #1;
            tests_run++;
            if (pt_valid !== 1'b1 || ct_ready !== 1'b0 || pt_data !== held) begin
                fails++;
                $display("FAIL bp_hold cycle %0d: pt_valid=%0b ct_ready=%0b pt_data=%0d required 1/0/%0d",
                         c, pt_valid, ct_ready, pt_data, held);
            end
        end
        ct_valid = 1'b0;
        pt_ready = 1'b1;
        @(posedge clk); #1;
        pt_ready = 1'b0;
        tests_run++;
        if (ct_ready !== 1'b1 || pt_valid !== 1'b0 || pt_data !== held) begin
            fails++;
            $display("FAIL bp_release: ct_ready=%0b pt_valid=%0b pt_data=%0d required 1/0/%0d",
                     ct_ready, pt_valid, pt_data, held);
        end
    endtask

    task automatic check_frame_err(input string name, input int nbeats, input int last_at);
        set_a_all(3);
        build_frame(200);
        send_beats(nbeats, last_at, 1'b0);
        tests_run++;
        if (frame_err !== 1'b1 || pt_valid !== 1'b0 || ct_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s pulse: frame_err=%0b pt_valid=%0b ct_ready=%0b required 1/0/1",
                     name, frame_err, pt_valid, ct_ready);
        end
        @(posedge clk); #1;
        tests_run++;
        if (frame_err !== 1'b0 || pt_valid !== 1'b0) begin
            fails++;
            $display("FAIL %s after: frame_err=%0b pt_valid=%0b required 0/0", name, frame_err, pt_valid);
        end
    endtask

    task automatic test_frame_errors;
        set_key_all(2);
        check_frame_err("err_early_last", 4, 3);
        check_frame_err("err_missing_last", N + 1, -1);
        set_a_all(5);
        decode_and_check("err_recover", 321, model_pt(321), 1'b0);
    endtask

    task automatic test_reset_mid;
        set_key_all(7);
        set_a_all(9);
        build_frame(500);
        send_beats(6, -1, 1'b0);
        rst_n = 1'b0;
        #2;
        tests_run++;
        if (ct_ready !== 1'b1 || pt_valid !== 1'b0 || pt_data !== 6'd0 || frame_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_async: ct_ready=%0b pt_valid=%0b pt_data=%0d frame_err=%0b required 1/0/0/0",
                     ct_ready, pt_valid, pt_data, frame_err);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        decode_and_check("reset_mid_next", 500, model_pt(500), 1'b0);
        build_frame(777);
        send_beats(N + 1, N, 1'b0);
        rst_n = 1'b0;
        #2;
        tests_run++;
        if (pt_valid !== 1'b0 || ct_ready !== 1'b1 || pt_data !== 6'd0) begin
            fails++;
            $display("FAIL reset_in_out: pt_valid=%0b ct_ready=%0b pt_data=%0d required 0/1/0",
                     pt_valid, ct_ready, pt_data);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Encrypt side of the loopback: b = <a,s> + e + m*(q/p) mod q with |e| small.
    task automatic test_loopback;
        for (int t = 0; t < 100; t++) begin
            int m;
            int e;
            int b;
            for (int i = 0; i < N; i++) begin
                key[i]   = 10'($urandom_range(0, Q - 1));
                a_vec[i] = $urandom_range(0, Q - 1);
            end
            m = $urandom_range(0, P - 1);
            e = int'($urandom_range(0, 6)) - 3;
            b = m * DEL + e;
            for (int i = 0; i < N; i++) b = b + a_vec[i] * int'(key[i]);
            b = ((b % Q) + Q) % Q;
            decode_and_check("loopback", b, m, t[0]);
        end
    endtask

    initial begin
        tests_run = 0;
        fails     = 0;
        rst_n     = 1'b0;
        ct_data   = '0;
        ct_valid  = 1'b0;
        ct_last   = 1'b0;
        pt_ready  = 1'b0;
        set_key_all(0);
        set_a_all(0);
        test_reset();
        test_basic();
        test_rounding();
        test_neg_wrap();
        test_random_stalls();
        test_backpressure();
        test_frame_errors();
        test_reset_mid();
        test_loopback();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
`default_nettype wire
